myfwdcut: RTL and testbench

- Forward-path timing cut for valid/ready streams; the counterpart of the ready-path loop cut.
- Registers `o_vld` and `data_o` through `STAGES` pipeline slots, so no combinational path runs from `i_vld`/`data_i` to `o_vld`/`data_o`.
- The ready path is combinational per stage, with bubble collapsing, so full throughput is kept.
- Placed between the 1553B decoder, APB register file and message buffers wherever the data/valid path fails timing.

---
 rtl/myfwdcut_pkg.sv | 14 +
 rtl/myfwdcut_stage.sv | 62 ++++++
 rtl/myfwdcut.sv | 107 ++++++++++
 tb/tb_myfwdcut.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/myfwdcut_pkg.sv
// myfwdcut_pkg: shared constants and helpers for the forward-path timing cut.
// Contents:
//   MIN_STAGES / MAX_STAGES : legal range of the STAGES parameter.
//   stages_in_range()       : elaboration-time range check on STAGES.
package myfwdcut_pkg;

  localparam int MIN_STAGES = 32'sd1;
  localparam int MAX_STAGES = 32'sd4;

  function automatic bit stages_in_range(input int stages);
    return (stages >= MIN_STAGES) && (stages <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/myfwdcut_stage.sv
// myfwdcut_stage: one valid/data register slot of the forward-path cut.
// Ports:
//   clk, rst (async, active-high), flush (sync clear of the valid flop)
//   up_vld / up_rdy / up_data : upstream side; up_rdy is combinational
//   dn_vld / dn_rdy / dn_data : downstream side; dn_vld/dn_data are flops
module myfwdcut_stage
  import myfwdcut_pkg::*;
#(
  parameter int    DW   = 32,
  parameter string NAME = "myfwdcut_stage"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_vld,
  output logic          up_rdy,
  input  logic [DW-1:0] up_data,
  output logic          dn_vld,
  input  logic          dn_rdy,
  output logic [DW-1:0] dn_data
);

  if (DW < MIN_STAGES) begin : g_bad_dw
    $error("%s: DW must be at least 1", NAME);
  end

  logic          vld_r;
  logic [DW-1:0] data_r;
  logic          rdy_s;

  // An empty slot always accepts; a full one only when its beat leaves.
  assign rdy_s = ~vld_r | dn_rdy;

  // Slot valid flop: flush empties it, otherwise it follows upstream when ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= 1'b0;
    end else if (flush) begin
      vld_r <= 1'b0;
    end else if (rdy_s) begin
      vld_r <= up_vld;
    end else begin
      vld_r <= vld_r;
    end
  end

  // Slot data flop: loads real beats only, so bubbles leave the last payload in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {DW{1'b0}};
    end else if (rdy_s & up_vld & ~flush) begin
      data_r <= up_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign up_rdy  = rdy_s;
  assign dn_vld  = vld_r;
  assign dn_data = data_r;

endmodule

// File: rtl/myfwdcut.sv
// myfwdcut: forward-path timing cut for valid/ready streams.
// Valid and data pass through STAGES register slots (no combinational path
// from i_vld/data_i to the outputs); ready ripples back combinationally with
// bubble collapsing, so one beat per cycle is sustained.
// Ports:
//   clk, rst (async, active-high), flush (sync clear of all slots and count)
//   i_vld / i_rdy / data_i : upstream stream (i_rdy forced low during flush)
//   o_vld / o_rdy / data_o : downstream stream, driven from last slot's flops
//   count                  : registered number of occupied slots
module myfwdcut
  import myfwdcut_pkg::*;
#(
  parameter int    DW     = 32,
  parameter int    STAGES = 2,
  parameter string NAME   = "myfwdcut"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         i_vld,
  output logic                         i_rdy,
  input  logic [DW-1:0]                data_i,
  output logic                         o_vld,
  input  logic                         o_rdy,
  output logic [DW-1:0]                data_o,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int CW = $clog2(STAGES + 1);

  if (!stages_in_range(STAGES)) begin : g_bad_stages
    $error("%s: STAGES=%0d outside %0d..%0d", NAME, STAGES, MIN_STAGES, MAX_STAGES);
  end

  // Slot 0 faces upstream, slot STAGES-1 faces downstream.
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic          up_vld_s;
    logic [DW-1:0] up_data_s;
    logic          rdy_in_s;
    logic          dn_rdy_s;
    logic          vld_out_s;
    logic [DW-1:0] data_out_s;

    if (k == 0) begin : g_first
      assign up_vld_s  = i_vld;
      assign up_data_s = data_i;
    end else begin : g_chain_in
      assign up_vld_s  = g_slot[k-1].vld_out_s;
      assign up_data_s = g_slot[k-1].data_out_s;
    end

    if (k == STAGES - 1) begin : g_last
      assign dn_rdy_s = o_rdy;
    end else begin : g_chain_out
      assign dn_rdy_s = g_slot[k+1].rdy_in_s;
    end

    myfwdcut_stage #(
      .DW   (DW),
      .NAME (NAME)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .up_vld  (up_vld_s),
      .up_rdy  (rdy_in_s),
      .up_data (up_data_s),
      .dn_vld  (vld_out_s),
      .dn_rdy  (dn_rdy_s),
      .dn_data (data_out_s)
    );
  end

  logic          acc_s;
  logic          emit_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  assign i_rdy  = g_slot[0].rdy_in_s & ~flush;
  assign o_vld  = g_slot[STAGES-1].vld_out_s;
  assign data_o = g_slot[STAGES-1].data_out_s;

  assign acc_s  = i_vld & i_rdy;
  assign emit_s = o_vld & o_rdy;

  // Occupancy update: flush empties everything, else +accept -emit.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      count_nxt_s = count_r + CW'(acc_s) - CW'(emit_s);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: tb/tb_myfwdcut.sv
// Self-checking bench for myfwdcut. Four instances (STAGES=1..4, DW=8);
// instance index g has STAGES=g+1, so index 1 is the STAGES=2 reference.
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge.
module tb_myfwdcut;
  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int BEATS = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_vld  [N];
  logic [DW-1:0] data_i [N];
  logic          o_rdy  [N];
  logic          flush  [N];
  logic          i_rdy  [N];
  logic          o_vld  [N];
  logic [DW-1:0] data_o [N];
  logic [2:0]    cnt    [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S  = g + 1;
    localparam int CW = $clog2(S + 1);
    logic [CW-1:0] c;
    myfwdcut #(.DW(DW), .STAGES(S), .NAME("tb_cut")) u_dut (
      .clk(clk), .rst(rst), .flush(flush[g]),
      .i_vld(i_vld[g]), .i_rdy(i_rdy[g]), .data_i(data_i[g]),
      .o_vld(o_vld[g]), .o_rdy(o_rdy[g]), .data_o(data_o[g]),
      .count(c)
    );
    assign cnt[g] = 3'(c);
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] sb [N][$];
  int            mcount [N];
  logic          acc_last [N];
  logic          prev_stall [N];
  logic [DW-1:0] prev_data [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the sampling point: scoreboard, count model and stall stability.
  task automatic track(input int g, input string tag);
    logic acc, emi;
    logic [DW-1:0] exp_d;
    acc = i_vld[g] & i_rdy[g];
    emi = o_vld[g] & o_rdy[g];
    check({tag, "_count"}, 32'(cnt[g]), 32'(mcount[g]));
    check({tag, "_count_le_stages"}, 32'(int'(cnt[g]) <= g + 1), 32'd1);
    if (prev_stall[g]) begin
      check({tag, "_stall_vld"}, 32'(o_vld[g]), 32'd1);
      check({tag, "_stall_data"}, 32'(data_o[g]), 32'(prev_data[g]));
    end
    if (emi) begin
      if (sb[g].size() == 0) begin
        check({tag, "_no_stale_beat"}, 32'(o_vld[g]), 32'd0);
      end else begin
        exp_d = sb[g].pop_front();
        check({tag, "_data"}, 32'(data_o[g]), 32'(exp_d));
      end
    end
    if (acc) sb[g].push_back(data_i[g]);
    if (flush[g]) mcount[g] = 0;
    else mcount[g] = mcount[g] + int'(acc) - int'(emi);
    acc_last[g]   = acc;
    prev_stall[g] = o_vld[g] & ~o_rdy[g];
    prev_data[g]  = data_o[g];
  endtask

  task automatic clear_model();
    for (int g = 0; g < N; g++) begin
      sb[g].delete();
      mcount[g]     = 0;
      acc_last[g]   = 1'b0;
      prev_stall[g] = 1'b0;
      prev_data[g]  = '0;
    end
  endtask

  typedef struct {
    logic          vld;
    logic [DW-1:0] din;
    logic          ordy;
    logic          fl;
    logic          e_irdy;
    logic          e_ovld;
    logic          chk_d;
    logic [DW-1:0] e_dout;
    logic [2:0]    e_cnt;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int first_acc, first_vld, cyc;
    bit all_done;
    int sent [N];

    // vld din ordy fl | irdy ovld chk_d dout cnt
    tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0}; // idle after reset
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd1};
    tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2}; // full: third beat refused
    tbl[4]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2}; // held stable
    tbl[5]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd2}; // release: emit+accept
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd2};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 3'd0}; // bubble keeps last data
    tbl[9]  = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 3'd0};
    tbl[10] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1};
    tbl[11] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 3'd2}; // flush beats 0x55
    tbl[12] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0}; // emptied, 0x55 gone
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h66, 3'd1}; // next beat comes first
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 3'd0};

    for (int g = 0; g < N; g++) begin
      i_vld[g] = 1'b0; data_i[g] = '0; o_rdy[g] = 1'b1; flush[g] = 1'b0;
    end
    clear_model();
    rst = 1'b1;
    #12;
    check("reset_irdy", 32'(i_rdy[1]), 32'd1);
    check("reset_ovld", 32'(o_vld[1]), 32'd0);
    check("reset_dout", 32'(data_o[1]), 32'd0);
    check("reset_count", 32'(cnt[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table on the STAGES=2 instance.
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #1;
      i_vld[1] = tbl[r].vld; data_i[1] = tbl[r].din;
      o_rdy[1] = tbl[r].ordy; flush[1] = tbl[r].fl;
      @(negedge clk);
      check($sformatf("tbl%0d_irdy", r), 32'(i_rdy[1]), 32'(tbl[r].e_irdy));
      check($sformatf("tbl%0d_ovld", r), 32'(o_vld[1]), 32'(tbl[r].e_ovld));
      check($sformatf("tbl%0d_count", r), 32'(cnt[1]), 32'(tbl[r].e_cnt));
      if (tbl[r].chk_d) check($sformatf("tbl%0d_dout", r), 32'(data_o[1]), 32'(tbl[r].e_dout));
    end
    @(posedge clk); #1;
    i_vld[1] = 1'b0; o_rdy[1] = 1'b1; flush[1] = 1'b0;
    clear_model();

    // Streaming 0x01..0x10 with o_rdy high: latency and steady occupancy.
    first_acc = -1; first_vld = -1;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      i_vld[1] = (c < 16); data_i[1] = (c < 16) ? DW'(c + 1) : '0;
      @(negedge clk);
      if (first_acc < 0 && i_vld[1] && i_rdy[1]) first_acc = c;
      if (first_vld < 0 && o_vld[1]) first_vld = c;
      if (c >= 2 && c <= 15) check("stream_count_steady", 32'(cnt[1]), 32'd2);
      track(1, "stream");
    end
    check("stream_first_latency", 32'(first_vld - first_acc), 32'd2);
    check("stream_drained", 32'(sb[1].size()), 32'd0);

    // Async reset pulse mid-stream, away from any clock edge.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      i_vld[1] = 1'b1; data_i[1] = DW'(8'h80 + c);
      @(negedge clk);
      track(1, "prerst");
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_ovld", 32'(o_vld[1]), 32'd0);
    check("async_rst_count", 32'(cnt[1]), 32'd0);
    check("async_rst_irdy", 32'(i_rdy[1]), 32'd1);
    i_vld[1] = 1'b0;
    clear_model();
    @(posedge clk); #3;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      i_vld[1] = (c < 6); data_i[1] = DW'(8'hC0 + c);
      @(negedge clk);
      track(1, "postrst");
    end
    check("postrst_drained", 32'(sb[1].size()), 32'd0);

    // Random traffic on all four depths.
    @(posedge clk); #1;
    for (int g = 0; g < N; g++) begin
      i_vld[g] = 1'b0; o_rdy[g] = 1'b0; flush[g] = 1'b0; sent[g] = 0;
    end
    clear_model();
    all_done = 1'b0;
    cyc = 0;
    while (!all_done && cyc < 20000) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      for (int g = 0; g < N; g++) begin
        if (i_vld[g] && !acc_last[g]) begin
          i_vld[g] = 1'b1;
        end else if (sent[g] < BEATS && $urandom_range(0, 99) < 70) begin
          i_vld[g] = 1'b1; data_i[g] = DW'($urandom); sent[g]++;
        end else begin
          i_vld[g] = 1'b0;
        end
        o_rdy[g] = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      for (int g = 0; g < N; g++) track(g, $sformatf("rand_s%0d", g + 1));
      all_done = 1'b1;
      for (int g = 0; g < N; g++)
        if (sent[g] < BEATS || (i_vld[g] && !acc_last[g]) || sb[g].size() != 0) all_done = 1'b0;
      cyc++;
    end
    check("rand_completed_in_budget", 32'(all_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
